// File: rtl/apb_slave_array.sv
// apb_slave_array: NSLV word-addressed APB slave memories behind one SETUP/ACCESS
// tracker with a fixed number of wait states per transfer.
// Ports:
//   Pclk, Preset      clock, synchronous active-high reset
//   Pselx[NSLV]       slave select (must be one-hot for a legal transfer)
//   Penable, Pwrite   APB phase and direction
//   Paddr[AW]         byte address; word index is Paddr[log2(DEPTH)+1:2]
//   Pwdata[DW]        write data
//   Prdata[DW]        read data, non-zero only in a clean read completion cycle
//   Pready, Pslverr   completion strobe and error flag (combinational)
module apb_slave_array #(
    parameter int unsigned NSLV        = 3,
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            Pclk,
    input  logic            Preset,
    input  logic [NSLV-1:0] Pselx,
    input  logic            Penable,
    input  logic            Pwrite,
    input  logic [AW-1:0]   Paddr,
    input  logic [DW-1:0]   Pwdata,
    output logic [DW-1:0]   Prdata,
    output logic            Pready,
    output logic            Pslverr
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [NSLV-1:0] cap_sel;
    logic            cap_write;
    logic [IW-1:0]   cap_idx;
    logic [DW-1:0]   cap_wdata;
    logic            cap_err;
    logic [SW-1:0]   sel_idx;
    logic            setup, active, capture, done, wr_en;
    logic            onehot, addr_err;
    logic [DW-1:0]   mem [NSLV][DEPTH];

    // Bus phase qualifiers
    assign setup  = (|Pselx) && !Penable;
    assign active = (|Pselx) && Penable;

    // Error decode: select not one-hot, misaligned, or beyond DEPTH words
    assign onehot   = (Pselx != '0) && ((Pselx & (Pselx - NSLV'(1))) == '0);
    assign addr_err = (Paddr[1:0] != 2'b00) || ((Paddr >> (IW + 2)) != '0);

    // State register
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; a SETUP seen in ACCESS restarts the transfer
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    capture   = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (setup) begin
                    capture = 1'b1;
                    cnt_nxt = 4'(WAIT_CYCLES);
                end else if (!active) begin
                    state_nxt = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer attributes held for the whole ACCESS phase
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            cap_sel   <= '0;
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_err   <= 1'b0;
        end else if (capture) begin
            cap_sel   <= Pselx;
            cap_write <= Pwrite;
            cap_idx   <= Paddr[IW+1:2];
            cap_wdata <= Pwdata;
            cap_err   <= !onehot || addr_err;
        end
    end

    // One-hot to index of the captured select
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (cap_sel[i]) sel_idx = SW'(i);
        end
    end

    assign wr_en = done && cap_write && !cap_err;

    // Slave memories
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            for (int unsigned s = 0; s < NSLV; s++) begin
                for (int unsigned w = 0; w < DEPTH; w++) begin
                    mem[s][w] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[sel_idx][cap_idx] <= cap_wdata;
        end
    end

    // Completion-cycle response
    assign Pready  = done;
    assign Pslverr = done && cap_err;
    assign Prdata  = (done && !cap_write && !cap_err) ? mem[sel_idx][cap_idx] : '0;

endmodule

// File: tb/tb_apb_slave_array.sv
// tb_apb_slave_array: directed checks of apb_slave_array with three instances
// (WAIT_CYCLES = 0, 3, 2), each driven by its own APB bus; shared clock and reset.
module tb_apb_slave_array;

    localparam int unsigned NI = 3;
    localparam int unsigned WC [NI] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  psel   [NI];
    logic        pen    [NI];
    logic        pwr    [NI];
    logic [31:0] paddr  [NI];
    logic [31:0] pwdata [NI];
    logic [31:0] prdata [NI];
    logic        pready [NI];
    logic        pslverr[NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_slave_array #(
            .NSLV(3), .DW(32), .AW(32), .DEPTH(16), .WAIT_CYCLES(WC[g])
        ) dut (
            .Pclk   (clk),
            .Preset (rst),
            .Pselx  (psel[g]),
            .Penable(pen[g]),
            .Pwrite (pwr[g]),
            .Paddr  (paddr[g]),
            .Pwdata (pwdata[g]),
            .Prdata (prdata[g]),
            .Pready (pready[g]),
            .Pslverr(pslverr[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transfer; entered and left #1 after a rising edge so calls chain back-to-back
    task automatic xfer(input int d, input logic [2:0] sel, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int waits);
        logic got;
        got   = 1'b0;
        rd    = '0;
        err   = 1'b0;
        waits = 0;
        psel[d] = sel; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = addr; pwdata[d] = wd;
        @(posedge clk); #1;
        pen[d] = 1'b1;
        // Bus address/data must be ignored during ACCESS
        paddr[d]  = 32'h0;
        pwdata[d] = 32'hA5A5_A5A5;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (pready[d]) begin
                got = 1'b1;
                rd  = prdata[d];
                err = pslverr[d];
            end else begin
                waits++;
                if (pslverr[d]) chk("slverr_without_ready", 32'(pslverr[d]), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("xfer_completed", 32'(got), 32'd1);
        psel[d] = '0;
        pen[d]  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int d, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] exp, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          wt;
        xfer(d, sel, 1'b0, addr, 32'h0, rd, err, wt);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_waits"}, 32'(wt), 32'(exp_waits));
    endtask

    task automatic outs_zero(input string tag);
        for (int d = 0; d < NI; d++) begin
            chk({tag, "_ready"}, 32'(pready[d]), 32'd0);
            chk({tag, "_slverr"}, 32'(pslverr[d]), 32'd0);
            chk({tag, "_rdata"}, prdata[d], 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          wt;

        for (int d = 0; d < NI; d++) begin
            psel[d] = '0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-wait instance: basic read, write, readback, per-slave isolation
        rd_chk("rd_s0_4", 0, 3'b001, 32'h4, 32'h0, 0);
        xfer(0, 3'b100, 1'b1, 32'h3C, 32'hDEAD_BEEF, rd, err, wt);
        chk("wr_s2_err", 32'(err), 32'd0);
        chk("wr_s2_rdata", rd, 32'd0);
        chk("wr_s2_waits", 32'(wt), 32'd0);
        rd_chk("rb_s2_3c", 0, 3'b100, 32'h3C, 32'hDEAD_BEEF, 0);
        rd_chk("rb_s0_3c", 0, 3'b001, 32'h3C, 32'h0, 0);
        rd_chk("rb_s1_3c", 0, 3'b010, 32'h3C, 32'h0, 0);

        // Three-wait instance: latency and back-to-back write then read
        rd_chk("w3_rd", 1, 3'b010, 32'h8, 32'h0, 3);
        xfer(1, 3'b010, 1'b1, 32'h8, 32'hCAFE_F00D, rd, err, wt);
        chk("w3_wr_waits", 32'(wt), 32'd3);
        rd_chk("w3_b2b_rd", 1, 3'b010, 32'h8, 32'hCAFE_F00D, 3);

        // Errored transfers leave memory untouched
        xfer(0, 3'b011, 1'b1, 32'h3C, 32'h1111_1111, rd, err, wt);
        chk("e_sel_err", 32'(err), 32'd1);
        chk("e_sel_rdata", rd, 32'd0);
        rd_chk("e_sel_rb0", 0, 3'b001, 32'h3C, 32'h0, 0);
        rd_chk("e_sel_rb1", 0, 3'b010, 32'h3C, 32'h0, 0);
        xfer(0, 3'b001, 1'b1, 32'h2, 32'h2222_2222, rd, err, wt);
        chk("e_mis_err", 32'(err), 32'd1);
        chk("e_mis_rdata", rd, 32'd0);
        rd_chk("e_mis_rb", 0, 3'b001, 32'h0, 32'h0, 0);
        xfer(0, 3'b001, 1'b1, 32'h40, 32'h3333_3333, rd, err, wt);
        chk("e_hi_err", 32'(err), 32'd1);
        chk("e_hi_rdata", rd, 32'd0);
        rd_chk("e_hi_rb", 0, 3'b001, 32'h0, 32'h0, 0);
        xfer(0, 3'b100, 1'b0, 32'h3E, 32'h0, rd, err, wt);
        chk("e_rd_err", 32'(err), 32'd1);
        chk("e_rd_rdata", rd, 32'd0);

        // Two-wait instance: select dropped in the 2nd ACCESS cycle of a write
        psel[2] = 3'b001; pwr[2] = 1'b1; paddr[2] = 32'h10; pwdata[2] = 32'h4444_4444;
        @(posedge clk); #1;
        pen[2] = 1'b1;
        @(negedge clk);
        chk("abort_c1_ready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        psel[2] = '0;
        @(negedge clk);
        chk("abort_c2_ready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        pen[2] = 1'b0;
        @(negedge clk);
        chk("abort_c3_ready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        rd_chk("abort_rb", 2, 3'b001, 32'h10, 32'h0, 2);

        // Penable without SETUP is ignored
        psel[0] = 3'b100; pen[0] = 1'b1; pwr[0] = 1'b1; paddr[0] = 32'h3C; pwdata[0] = 32'h6666_6666;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("nosetup_ready", 32'(pready[0]), 32'd0);
            @(posedge clk); #1;
        end
        psel[0] = '0; pen[0] = 1'b0;
        rd_chk("nosetup_rb", 0, 3'b100, 32'h3C, 32'hDEAD_BEEF, 0);

        // Reset in the middle of a wait-stated write
        psel[1] = 3'b100; pwr[1] = 1'b1; paddr[1] = 32'h3C; pwdata[1] = 32'h5555_5555;
        @(posedge clk); #1;
        pen[1] = 1'b1;
        @(negedge clk);
        chk("rstmid_c1_ready", 32'(pready[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outs_zero("rstmid");
        @(posedge clk); #1;
        rst = 1'b0;
        psel[1] = '0; pen[1] = 1'b0;
        rd_chk("rstmid_rb_w3", 1, 3'b100, 32'h3C, 32'h0, 3);
        rd_chk("rstmid_rb_w0", 0, 3'b100, 32'h3C, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
